// File: rtl/attention_sched.sv
// attention_sched: start/done sequencer feeding the MX softmax rows.
// Optional softmax-output watchdog: define ATTN_SCHED_WATCHDOG_EN.
module attention_sched #(
  parameter int S_kv = 4,
  parameter int k = 2,
  parameter int MM1_LAT = 2,
  parameter int MM2_LAT = 2,
  parameter int TO_CYCLES = 64,
  localparam int CW = $clog2(S_kv),
  localparam int BW = (S_kv / k > 1) ? $clog2(S_kv / k) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_sm_vld,
  input  logic          i_sm_rdy,
  output logic [CW-1:0] o_sm_col,
  input  logic          i_sm_ovld,
  output logic          o_cap_en,
  output logic [CW-1:0] o_cap_col,
  output logic [BW-1:0] o_cap_blk,
  output logic          o_err
);

  localparam int KW = $clog2(k);
  localparam int WMAX = (MM1_LAT > MM2_LAT) ? MM1_LAT : MM2_LAT;
  localparam int WW = $clog2(WMAX + 1);
  localparam logic [CW:0] CAP_END = (CW+1)'(S_kv);
  localparam logic [CW-1:0] COL_LAST = CW'(S_kv - 1);

  if (S_kv < k || MM1_LAT < 1 || MM2_LAT < 1 || TO_CYCLES < 1)
  begin : g_bad_cfg
    $error("attention_sched: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    MM1_WAIT,
    SM_FEED,
    SM_DRAIN,
    MM2_WAIT
  } state_t;

  state_t        state, state_d;
  logic [WW-1:0] wait_cnt, wait_d;
  logic [CW-1:0] iss_cnt, iss_d;
  logic [CW:0]   cap_cnt, cap_d;
  logic          in_sm;
  logic          cap_en;

`ifdef ATTN_SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(TO_CYCLES + 1);
  logic [WDW-1:0] wd_cnt, wd_d;
  logic           err_q, err_d;
`endif

  assign in_sm  = (state == SM_FEED) || (state == SM_DRAIN);
  // Beats past the S_kv-th are stray and must not move the counter.
  assign cap_en = in_sm && i_sm_ovld && (cap_cnt != CAP_END);

  always_comb begin
    state_d = state;
    wait_d  = wait_cnt;
    iss_d   = iss_cnt;
    cap_d   = cap_cnt;
`ifdef ATTN_SCHED_WATCHDOG_EN
    wd_d    = wd_cnt;
    err_d   = err_q;
`endif
    if (cap_en) cap_d = cap_cnt + (CW+1)'(1);
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_d = MM1_WAIT;
          wait_d  = WW'(MM1_LAT - 1);
          iss_d   = '0;
          cap_d   = '0;
`ifdef ATTN_SCHED_WATCHDOG_EN
          wd_d    = '0;
          err_d   = 1'b0;
`endif
        end
      end
      MM1_WAIT: begin
        if (wait_cnt == '0) state_d = SM_FEED;
        else wait_d = wait_cnt - WW'(1);
      end
      SM_FEED: begin
        if (i_sm_rdy) begin
          iss_d = iss_cnt + CW'(1);
          if (iss_cnt == COL_LAST) state_d = SM_DRAIN;
        end
      end
      SM_DRAIN: begin
        if (cap_cnt == CAP_END) begin
          state_d = MM2_WAIT;
          wait_d  = WW'(MM2_LAT - 1);
        end
      end
      MM2_WAIT: begin
        if (wait_cnt == '0) state_d = IDLE;
        else wait_d = wait_cnt - WW'(1);
      end
      default: state_d = IDLE;
    endcase
`ifdef ATTN_SCHED_WATCHDOG_EN
    // Timeout overrides any feed/drain progress made this cycle.
    if (in_sm) begin
      if (cap_en) begin
        wd_d = '0;
      end else if (wd_cnt == WDW'(TO_CYCLES - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_cnt + WDW'(1);
      end
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      iss_cnt  <= '0;
      cap_cnt  <= '0;
`ifdef ATTN_SCHED_WATCHDOG_EN
      wd_cnt   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      iss_cnt  <= iss_d;
      cap_cnt  <= cap_d;
`ifdef ATTN_SCHED_WATCHDOG_EN
      wd_cnt   <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  assign o_busy    = (state != IDLE);
  assign o_sm_vld  = (state == SM_FEED);
  assign o_done    = (state == MM2_WAIT) && (wait_cnt == '0);
  assign o_sm_col  = iss_cnt;
  assign o_cap_en  = cap_en;
  assign o_cap_col = cap_cnt[CW-1:0];
  assign o_cap_blk = BW'(o_cap_col >> KW);

`ifdef ATTN_SCHED_WATCHDOG_EN
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
